mem_wb_skid_reg: RTL
====================

MEM_WB_SKID_REG -- requirements
Module: mem_wb_skid_reg

Interface
REQ-001 The module SHALL expose parameter DATA_W, 32, width of memory read word and ALU result.
REQ-002 The module SHALL expose parameter BYTE_W, 8, width of byte read port.
REQ-003 The module SHALL expose parameter RG_W, 4, width of destination register index.
REQ-004 The module SHALL expose parameter CNT_W, 16, width of stall-cycle counter.
REQ-005 The module SHALL have port clk input 1 sole clock, rising edge.
REQ-006 The module SHALL have port rst_n input 1 asynchronous active-low reset.
REQ-007 The module SHALL have port flush input 1 synchronous squash of all held entries.
REQ-008 The module SHALL have port in_valid input 1 MEM stage presents an entry.
REQ-009 The module SHALL have port in_ready output 1 block can accept an entry.
REQ-010 The module SHALL have payload inputs Do_In DATA_W, Dob_In BYTE_W, ALU_Result_In DATA_W, Rg_In RG_W, and WE_C_In, WE_V_In, SEL_C_In, SEL_DAT_In, PROHIB_MEM (1 bit each).
REQ-011 The module SHALL have port out_valid output 1 WB entry valid.
REQ-012 The module SHALL have port out_ready input 1 WB consumes entry.
REQ-013 The module SHALL have payload outputs Do, Dob, ALU_Result, Rg, WE_C, WE_V, SEL_C, SEL_DAT, PROHIB_WB, widths matching the inputs.
REQ-014 The module SHALL have port stall_cnt output CNT_W count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 The storage SHALL be a main register feeding the outputs plus one skid register; an entry is accepted when in_valid and in_ready are both 1.
REQ-016 in_ready SHALL be driven directly from a flop as the inverse of skid-full, with no combinational path from out_ready.
REQ-017 An entry accepted while main is empty, or while main drains in the same cycle with skid empty, SHALL appear on the outputs with out_valid=1 the next cycle (latency 1).
REQ-018 An entry accepted while main is full and not draining SHALL be written to skid; skid SHALL move to main on the first cycle main drains.
REQ-019 Output order SHALL equal acceptance order; no entry is dropped or duplicated.
REQ-020 Rg SHALL be registered with the rest of the payload, not passed through.
REQ-021 When PROHIB of the main entry is 1, outputs WE_C and WE_V SHALL read 0 while PROHIB_WB reads 1; the other payload fields pass unchanged.
REQ-022 When out_valid=0, WE_C and WE_V SHALL read 0 regardless of held data.
REQ-023 flush SHALL clear both valid bits at the next edge, override a simultaneous accept, and leave in_ready=1 the following cycle.
REQ-024 stall_cnt SHALL increment on every cycle with out_valid=1 and out_ready=0, saturate at all-ones, and not be cleared by flush.
REQ-025 States SHALL be EMPTY (both invalid), ONE (main valid), and FULL (both valid); transitions follow REQ-017, REQ-018, and REQ-023, and the skid SHALL never be valid while main is invalid.

Reset
REQ-026 Assertion of rst_n=0 SHALL immediately force out_valid=0, in_ready=1, stall_cnt=0, all payload outputs to 0, and state EMPTY.
REQ-027 Reset mid-transfer SHALL discard held entries; the first edge after deassertion SHALL accept normally.

Structure
REQ-028 The default widths and the state encoding SHALL live in the shared pipeline package used by all stage registers.
REQ-029 One sub-module, pipe_payload_reg, SHALL implement a parametrised payload flop with load enable, instanced for main and skid.

Verification
REQ-030 Reset: hold rst_n=0 with in_valid=1 -> in_ready=1, out_valid=0, stall_cnt=0, WE_C=0.
REQ-031 Streaming: out_ready=1, in_valid=1 for 4 cycles with ALU_Result_In 1..4 -> ALU_Result 1..4 on consecutive cycles, each 1 cycle after acceptance.
REQ-032 Backpressure: out_ready=0, push A then B -> in_ready=0 after B, stall_cnt counts up; raise out_ready -> A then B delivered, in_ready=1.
REQ-033 Prohibit: push WE_C_In=1, WE_V_In=1, PROHIB_MEM=1, Rg_In=4'hA -> WE_C=0, WE_V=0, PROHIB_WB=1, Rg=4'hA.
REQ-034 Flush: FULL state, then flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, stall_cnt unchanged.
REQ-035 Saturation: CNT_W=4, out_ready=0 held for 20 cycles with an entry held -> stall_cnt stops at 15.

Source files
------------

// File: rtl/mem_wb_skid_reg_pkg.sv
// mem_wb_skid_reg_pkg: shared pipeline defaults, skid-register state encoding and payload width helper
package mem_wb_skid_reg_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int BYTE_W_DEF = 8;
  localparam int RG_W_DEF   = 4;
  localparam int CNT_W_DEF  = 16;
  // ST_FULL implies ST_ONE's main bit, so skid is never valid without main
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_e;
  // Do, Dob, ALU_Result, Rg and the five single-bit controls packed into one vector
  function automatic int payload_w(input int dw, input int bw, input int rw);
    return 2 * dw + bw + rw + 5;
  endfunction
endpackage

// File: rtl/pipe_payload_reg.sv
// pipe_payload_reg: parametrised payload flop with load enable, async active-low reset to zero
//   clk/rst_n : clock, asynchronous active-low reset
//   en_i      : load d_i on the rising edge
//   d_i / q_o : payload in / registered payload out
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_q <= '0;
    else if (en_i) data_q <= d_i;
  assign q_o = data_q;
endmodule

// File: rtl/mem_wb_skid_reg.sv
// mem_wb_skid_reg: MEM/WB pipeline register with one-entry skid buffer, write prohibit and stall counter
//   clk, rst_n, flush            : clock, async active-low reset, sync squash of held entries
//   in_valid/in_ready + *_In     : MEM-side handshake and payload (in_ready is a pure flop)
//   out_valid/out_ready + outputs: WB-side handshake and registered payload
//   stall_cnt                    : saturating count of cycles with out_valid=1 and out_ready=0
module mem_wb_skid_reg
  import mem_wb_skid_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int RG_W   = RG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Do_In,
  input  logic [BYTE_W-1:0] Dob_In,
  input  logic [DATA_W-1:0] ALU_Result_In,
  input  logic [RG_W-1:0]   Rg_In,
  input  logic              WE_C_In,
  input  logic              WE_V_In,
  input  logic              SEL_C_In,
  input  logic              SEL_DAT_In,
  input  logic              PROHIB_MEM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Do,
  output logic [BYTE_W-1:0] Dob,
  output logic [DATA_W-1:0] ALU_Result,
  output logic [RG_W-1:0]   Rg,
  output logic              WE_C,
  output logic              WE_V,
  output logic              SEL_C,
  output logic              SEL_DAT,
  output logic              PROHIB_WB,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int PW = payload_w(DATA_W, BYTE_W, RG_W);
  skid_state_e state_q, state_d;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic rdy_q, out_v, acc, drain, main_en, skid_en, we_c_raw, we_v_raw;
  assign in_pl = {Do_In, Dob_In, ALU_Result_In, Rg_In, WE_C_In, WE_V_In, SEL_C_In, SEL_DAT_In, PROHIB_MEM};
  assign out_v = state_q != ST_EMPTY;
  assign acc   = in_valid & rdy_q;
  assign drain = out_v & out_ready;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: state_d = acc ? ST_ONE : ST_EMPTY;
      ST_ONE:   state_d = (acc & ~drain) ? ST_FULL : (~acc & drain) ? ST_EMPTY : ST_ONE;
      ST_FULL:  state_d = drain ? ST_ONE : ST_FULL;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end
  // main reloads from skid when draining while full, otherwise straight from the input
  always_comb begin
    main_en = (state_q == ST_FULL) ? drain : acc & ((state_q == ST_EMPTY) | drain);
    main_d  = (state_q == ST_FULL) ? skid_q : in_pl;
    skid_en = (state_q == ST_ONE) & acc & ~drain;
    cnt_d   = (out_v & ~out_ready & ~&cnt_q) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end
  // in_ready comes from its own flop so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d != ST_FULL;
      cnt_q   <= cnt_d;
    end
  pipe_payload_reg #(.W(PW)) u_main (.clk(clk), .rst_n(rst_n), .en_i(main_en), .d_i(main_d), .q_o(main_q));
  pipe_payload_reg #(.W(PW)) u_skid (.clk(clk), .rst_n(rst_n), .en_i(skid_en), .d_i(in_pl), .q_o(skid_q));
  assign {Do, Dob, ALU_Result, Rg, we_c_raw, we_v_raw, SEL_C, SEL_DAT, PROHIB_WB} = main_q;
  // writes are suppressed for prohibited entries and whenever nothing valid is presented
  assign WE_C      = we_c_raw & out_v & ~PROHIB_WB;
  assign WE_V      = we_v_raw & out_v & ~PROHIB_WB;
  assign in_ready  = rdy_q;
  assign out_valid = out_v;
  assign stall_cnt = cnt_q;
endmodule
